push_button_debouncer: RTL and testbench
========================================

# push_button_debouncer

Per-channel synchronizer, debouncer and edge detector for the DE10-Lite KEY push buttons. It sits directly upstream of the push-button PIO input port: its debounced level output drives the PIO `in_port`. Software therefore reads clean, active-high button levels. One-cycle press and release pulses are also exported for hardware consumers such as an edge-capture or interrupt stage.

## Interface

Parameters:
- `WIDTH`, default 2: number of button channels.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz). Minimum 1; 0 is illegal.
- `ACTIVE_LOW`, default 1: 1 means the raw pin reads 0 when the button is pressed, and the block inverts it.
- Counter width is derived as `$clog2(DEBOUNCE_CYCLES+1)`.

Ports:
- `clk`, input, 1: the single system clock; all logic is on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `button_raw`, input, WIDTH: asynchronous pin levels from the KEY inputs.
- `debounced`, output, WIDTH: debounced level per channel, 1 = pressed. Connects to PIO `in_port`.
- `press_pulse`, output, WIDTH: 1-cycle pulse when a channel's `debounced` goes 0→1.
- `release_pulse`, output, WIDTH: 1-cycle pulse when a channel's `debounced` goes 1→0.

## Operation

- **Normalize.** `p = ACTIVE_LOW ? ~button_raw : button_raw`, so 1 = pressed.
- **Synchronize.** Two-flop synchronizer per channel: `sync1 <= p`, `s <= sync1`. No logic sits between the two flops.
- **Channel FSM.** Each channel runs an independent FSM with a counter `cnt`. States:
  - RELEASED: `debounced` = 0. If `s` = 1, go to CONFIRM_PRESS with `cnt` = 1. If `DEBOUNCE_CYCLES` = 1, accept immediately instead (see below).
  - CONFIRM_PRESS:
    - If `s` = 0, return to RELEASED and clear `cnt` to 0.
    - Else if `cnt` = `DEBOUNCE_CYCLES`−1, go to PRESSED with `debounced` <= 1, `press_pulse` <= 1, `cnt` <= 0.
    - Else `cnt` <= `cnt`+1.
  - PRESSED: `debounced` = 1. If `s` = 0, go to CONFIRM_RELEASE with `cnt` = 1, or accept immediately if `DEBOUNCE_CYCLES` = 1.
  - CONFIRM_RELEASE: mirror image of CONFIRM_PRESS; on acceptance `debounced` <= 0 and `release_pulse` <= 1.
- **Acceptance rule.** A new level is accepted on the `DEBOUNCE_CYCLES`-th consecutive rising edge at which `s` differs from `debounced`.
- **Glitches.** Any single-cycle return of `s` to the current `debounced` value clears the count. There is no partial credit.
- **Outputs.** All outputs are registered.
- **Pulses.**
  - `press_pulse` and `release_pulse` are high for exactly one cycle, in the same cycle that `debounced` changes.
  - They are never both high on the same channel.
- **Counter range.** `cnt` never exceeds `DEBOUNCE_CYCLES`−1 and never wraps.
- **Channel independence.** Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses.

## Timing

- **Reset values** (asynchronous assertion, while `reset` = 1):
  - `sync1`, `s`, `debounced`, `press_pulse`, `release_pulse`: all 0 (released).
  - `cnt`: 0.
  - All FSMs: RELEASED.
- **Reset release.** The first active edge is the first rising edge with `reset` = 0.
- **Button held at reset release.** A button already pressed at reset release is treated as a new press and produces `press_pulse` after the normal latency.
- **Latency.** A level change of `button_raw` that is stable from edge 0 (the first edge that samples it into `sync1`) appears on `debounced` and the pulse output at edge `DEBOUNCE_CYCLES`+1.
  - For N = 4, that is 6 edges counting edge 0.
- **Minimum accepted press.** A raw pulse must span `DEBOUNCE_CYCLES`+... exactly `DEBOUNCE_CYCLES` samples at `s`; shorter pulses produce no output change.
- **Reset mid-confirmation.** All state returns to reset values immediately. The pulse in flight is lost and no pulse is emitted.
- **Throughput.** One accepted transition per channel per `DEBOUNCE_CYCLES` cycles at most.

## Test plan

All scenarios use `DEBOUNCE_CYCLES` = 4, `WIDTH` = 2, `ACTIVE_LOW` = 1.

- **Reset.** Assert `reset` with `button_raw` = 2'b00 (both pressed).
  - During reset, `debounced` = 0 and both pulse outputs = 0.
  - After release, `debounced` = 2'b11 at edge 5 after release, with `press_pulse` = 2'b11 for that one cycle.
- **Clean press.** Drive `button_raw[0]` 1→0 and hold.
  - `debounced[0]` rises on the 6th edge (counting the capture edge as edge 0).
  - `press_pulse[0]` is high for exactly 1 cycle.
  - `debounced[1]` stays 0 and `release_pulse` stays 0.
- **Bounce.** While released, toggle `button_raw[0]` low for 3 cycles, high for 1, low for 3, then high.
  - `debounced[0]` stays 0 and no pulses are emitted.
- **Release.** From the pressed state, drive `button_raw[0]` high and hold.
  - `debounced[0]` falls 5 edges after capture.
  - `release_pulse[0]` is high for 1 cycle and `press_pulse[0]` stays 0.
- **Simultaneous.** Press both channels on the same edge.
  - `press_pulse` = 2'b11 in a single cycle and `debounced` = 2'b11 together.
- **Reset mid-confirmation.** Assert `reset` 2 cycles into CONFIRM_PRESS.
  - All outputs are 0 immediately, with no stray pulse.
  - After reset release with the button held, a full new latency of 5 edges applies.

Source files
------------

// File: rtl/push_button_debouncer.sv
// push_button_debouncer
//   Per-channel synchronizer, debouncer and edge detector for the KEY push
//   buttons. The debounced level drives the push-button PIO in_port, so
//   software reads clean active-high levels. One-cycle press/release pulses
//   are exported for edge-capture or interrupt logic.
//
// Parameters
//   WIDTH           number of button channels
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a new level (>= 1)
//   ACTIVE_LOW      1: raw pin reads 0 while pressed
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-high
//   button_raw      asynchronous pin levels
//   debounced       debounced level per channel, 1 = pressed
//   press_pulse     1-cycle pulse when debounced goes 0->1
//   release_pulse   1-cycle pulse when debounced goes 1->0
module push_button_debouncer #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] button_raw,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam bit IMMEDIATE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        RELEASED,
        CONFIRM_PRESS,
        PRESSED,
        CONFIRM_RELEASE
    } state_t;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] s;

    assign p = ACTIVE_LOW ? ~button_raw : button_raw;

    // Plain two-flop synchronizer, nothing between the stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= p;
            s     <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_t        state;
        logic [CW-1:0] cnt;
        logic          deb_r;
        logic          press_r;
        logic          release_r;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state     <= RELEASED;
                cnt       <= '0;
                deb_r     <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                press_r   <= 1'b0;
                release_r <= 1'b0;
                case (state)
                    RELEASED: begin
                        if (s[i]) begin
                            if (IMMEDIATE) begin
                                state   <= PRESSED;
                                deb_r   <= 1'b1;
                                press_r <= 1'b1;
                                cnt     <= '0;
                            end else begin
                                state <= CONFIRM_PRESS;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    CONFIRM_PRESS: begin
                        if (!s[i]) begin
                            // any return to the accepted level forfeits all progress
                            state <= RELEASED;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= PRESSED;
                            deb_r   <= 1'b1;
                            press_r <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!s[i]) begin
                            if (IMMEDIATE) begin
                                state     <= RELEASED;
                                deb_r     <= 1'b0;
                                release_r <= 1'b1;
                                cnt       <= '0;
                            end else begin
                                state <= CONFIRM_RELEASE;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    CONFIRM_RELEASE: begin
                        if (s[i]) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state     <= RELEASED;
                            deb_r     <= 1'b0;
                            release_r <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= RELEASED;
                        cnt   <= '0;
                        deb_r <= 1'b0;
                    end
                endcase
            end
        end

        assign debounced[i]     = deb_r;
        assign press_pulse[i]   = press_r;
        assign release_pulse[i] = release_r;
    end

endmodule

// File: tb/tb_push_button_debouncer.sv
module tb_push_button_debouncer;

    localparam int W = 2;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] button_raw = 2'b00;
    logic [W-1:0] debounced;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;

    push_button_debouncer #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(N),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .button_raw(button_raw),
        .debounced(debounced),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int np_total = 0;
    int nr_total = 0;

    // Reference: the level seen by the debouncer lags the pin by two edges;
    // a channel flips once it has seen N consecutive samples disagreeing
    // with its current level.
    logic [W-1:0] pq[$];
    logic [W-1:0] mdeb, mpp, mrp;
    int           run[W];

    typedef struct {
        logic [W-1:0] raw;
        int           hold;
        logic [W-1:0] exp_deb;
        int           exp_np;
        int           exp_nr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pq.delete();
        pq.push_back('0);
        pq.push_back('0);
        mdeb = '0;
        mpp  = '0;
        mrp  = '0;
        for (int c = 0; c < W; c++) run[c] = 0;
    endtask

    task automatic model_step(input logic [W-1:0] p_now);
        logic [W-1:0] s_used;
        s_used = pq.pop_front();
        pq.push_back(p_now);
        mpp = '0;
        mrp = '0;
        for (int c = 0; c < W; c++) begin
            if (s_used[c] != mdeb[c]) begin
                run[c]++;
                if (run[c] == N) begin
                    mdeb[c] = ~mdeb[c];
                    if (mdeb[c]) mpp[c] = 1'b1;
                    else         mrp[c] = 1'b1;
                    run[c] = 0;
                end
            end else begin
                run[c] = 0;
            end
        end
    endtask

    task automatic tick();
        logic [W-1:0] p_now;
        p_now = ~button_raw;
        @(posedge clk);
        #1;
        if (reset) model_reset();
        else       model_step(p_now);
        check("model", 32'({debounced, press_pulse, release_pulse}), 32'({mdeb, mpp, mrp}));
        check("exclusive", 32'(press_pulse & release_pulse), 32'(0));
        np_total += $countones(press_pulse);
        nr_total += $countones(release_pulse);
    endtask

    // Apply a new raw value after an edge and check the exact acceptance edge.
    task automatic latency_seq(input string name, input logic [W-1:0] raw_new,
                               input logic [W-1:0] prev_deb, input logic [W-1:0] exp_deb,
                               input logic [W-1:0] exp_pp, input logic [W-1:0] exp_rp);
        button_raw = raw_new;
        for (int k = 0; k <= 6; k++) begin
            tick();
            if (k == 4) begin
                check({name, "_edge4_deb"}, 32'(debounced), 32'(prev_deb));
                check({name, "_edge4_pulses"}, 32'({press_pulse, release_pulse}), 32'(0));
            end
            if (k == 5) begin
                check({name, "_edge5_deb"}, 32'(debounced), 32'(exp_deb));
                check({name, "_edge5_press"}, 32'(press_pulse), 32'(exp_pp));
                check({name, "_edge5_release"}, 32'(release_pulse), 32'(exp_rp));
            end
            if (k == 6) check({name, "_edge6_pulses"}, 32'({press_pulse, release_pulse}), 32'(0));
        end
    endtask

    initial begin
        vec_t tbl[6];
        int   np0, nr0;
        int   hold_left[W];

        model_reset();

        // Reset with both buttons pressed
        button_raw = 2'b00;
        reset = 1'b1;
        repeat (3) tick();
        check("reset_outputs", 32'({debounced, press_pulse, release_pulse}), 32'(0));
        reset = 1'b0;
        latency_seq("reset_held", 2'b00, 2'b00, 2'b11, 2'b11, 2'b00);

        // Release both
        latency_seq("release_both", 2'b11, 2'b11, 2'b00, 2'b00, 2'b11);

        // Clean press and release on channel 0
        np0 = np_total;
        nr0 = nr_total;
        latency_seq("press0", 2'b10, 2'b00, 2'b01, 2'b01, 2'b00);
        check("press0_one_pulse", 32'(np_total - np0), 32'(1));
        check("press0_no_release", 32'(nr_total - nr0), 32'(0));
        np0 = np_total;
        nr0 = nr_total;
        latency_seq("release0", 2'b11, 2'b01, 2'b00, 2'b00, 2'b01);
        check("release0_no_press", 32'(np_total - np0), 32'(0));
        check("release0_one_pulse", 32'(nr_total - nr0), 32'(1));

        // Bounce: 3 low, 1 high, 3 low, then high
        np0 = np_total;
        nr0 = nr_total;
        button_raw = 2'b10; repeat (3) tick();
        button_raw = 2'b11; tick();
        button_raw = 2'b10; repeat (3) tick();
        button_raw = 2'b11; repeat (8) tick();
        check("bounce_deb", 32'(debounced), 32'(0));
        check("bounce_pulses", 32'((np_total - np0) + (nr_total - nr0)), 32'(0));

        // Simultaneous press on both channels
        latency_seq("simul", 2'b00, 2'b00, 2'b11, 2'b11, 2'b00);
        latency_seq("simul_rel", 2'b11, 2'b11, 2'b00, 2'b00, 2'b11);

        // Reset mid-confirmation while channel 1 is already pressed
        latency_seq("press1", 2'b01, 2'b00, 2'b10, 2'b10, 2'b00);
        button_raw = 2'b00;
        repeat (4) tick();
        #3 reset = 1'b1;
        #1;
        check("reset_mid_async", 32'({debounced, press_pulse, release_pulse}), 32'(0));
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        latency_seq("after_reset", 2'b00, 2'b00, 2'b11, 2'b11, 2'b00);
        latency_seq("after_reset_rel", 2'b11, 2'b11, 2'b00, 2'b00, 2'b11);

        // Table-driven vectors, starting released with raw = 11
        tbl[0] = '{raw: 2'b10, hold: 8, exp_deb: 2'b01, exp_np: 1, exp_nr: 0};
        tbl[1] = '{raw: 2'b00, hold: 8, exp_deb: 2'b11, exp_np: 1, exp_nr: 0};
        tbl[2] = '{raw: 2'b10, hold: 3, exp_deb: 2'b11, exp_np: 0, exp_nr: 0};
        tbl[3] = '{raw: 2'b00, hold: 6, exp_deb: 2'b11, exp_np: 0, exp_nr: 0};
        tbl[4] = '{raw: 2'b11, hold: 8, exp_deb: 2'b00, exp_np: 0, exp_nr: 2};
        tbl[5] = '{raw: 2'b01, hold: 8, exp_deb: 2'b10, exp_np: 1, exp_nr: 0};
        for (int v = 0; v < 6; v++) begin
            np0 = np_total;
            nr0 = nr_total;
            button_raw = tbl[v].raw;
            repeat (tbl[v].hold) tick();
            check($sformatf("vec%0d_deb", v), 32'(debounced), 32'(tbl[v].exp_deb));
            check($sformatf("vec%0d_np", v), 32'(np_total - np0), 32'(tbl[v].exp_np));
            check($sformatf("vec%0d_nr", v), 32'(nr_total - nr0), 32'(tbl[v].exp_nr));
        end

        // Randomized per-channel hold lengths straddling the debounce window
        for (int c = 0; c < W; c++) hold_left[c] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < W; c++) begin
                if (hold_left[c] == 0) begin
                    button_raw[c] = 1'($urandom_range(0, 1));
                    hold_left[c]  = int'($urandom_range(1, 7));
                end
                hold_left[c]--;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
